// File: rtl/add_pkg.sv
// Shared constants and helpers for the registered adder.
package add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_LATENCY   = 4;

    // Result width of an unsigned w-bit add, including carry-out.
    function automatic int unsigned sum_width(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One pipeline register holding a result word and its valid bit.
module add_pipe_stage
    import add_pkg::*;
#(
    parameter int unsigned DATA_W = sum_width(DEFAULT_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/add_reg.sv
// Registered unsigned adder with LATENCY register stages and a travelling valid.
module add_reg
    import add_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          in_valid,
    output logic [sum_width(WIDTH)-1:0]   sum,
    output logic                          out_valid
);

    localparam int unsigned SW = sum_width(WIDTH);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("add_reg: LATENCY must be in 1..%0d", MAX_LATENCY);
        end
    endgenerate

    logic [SW-1:0] w_data  [LATENCY+1];
    logic          w_valid [LATENCY+1];

    // Zero-extended add at full result width, so carry is never lost.
    assign w_data[0]  = SW'(a) + SW'(b);
    assign w_valid[0] = in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            add_pipe_stage #(
                .DATA_W (SW)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_data  (w_data[gi]),
                .i_valid (w_valid[gi]),
                .o_data  (w_data[gi+1]),
                .o_valid (w_valid[gi+1])
            );
        end
    endgenerate

    assign sum       = w_data[LATENCY];
    assign out_valid = w_valid[LATENCY];

endmodule

// File: tb/tb_add_reg.sv
// Randomized and directed checks of add_reg at LATENCY=1 and LATENCY=3 against an edge-history model.
module tb_add_reg;

    localparam int unsigned W    = 4;
    localparam int          HMAX = 2048;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         in_valid;
    logic [W:0]   sum1, sum3;
    logic         vld1, vld3;

    int tests  = 0;
    int errors = 0;

    // History of what every rising edge sampled; index = edge number (1-based).
    int   n = 0;
    int   ha [HMAX];
    int   hb [HMAX];
    logic hv [HMAX];
    logic hr [HMAX];

    always #5 clk = ~clk;

    add_reg #(.WIDTH(W), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .sum(sum1), .out_valid(vld1)
    );

    add_reg #(.WIDTH(W), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .sum(sum3), .out_valid(vld3)
    );

    always @(posedge clk) begin
        if (n + 1 < HMAX) begin
            n          <= n + 1;
            ha[n + 1]  <= int'(a);
            hb[n + 1]  <= int'(b);
            hv[n + 1]  <= in_valid;
            hr[n + 1]  <= ~rst_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // After edge n, the output shows the operands sampled at edge n-L+1,
    // unless any reset edge occurred in that window.
    function automatic void model(input int lat, output logic [W:0] es, output logic ev);
        int s;
        int lo;
        s  = n - lat + 1;
        lo = (s < 1) ? 1 : s;
        es = '0;
        ev = 1'b0;
        for (int j = lo; j <= n; j++) begin
            if (hr[j]) return;
        end
        if (s < 1) return;
        es = (W+1)'(ha[s] + hb[s]);
        ev = hv[s];
    endfunction

    task automatic check_model();
        logic [W:0] es;
        logic       ev;
        model(1, es, ev);
        chk("sum_l1", 32'(sum1), 32'(es));
        chk("vld_l1", 32'(vld1), 32'(ev));
        model(3, es, ev);
        chk("vld_l3", 32'(vld3), 32'(ev));
        if (ev) chk("sum_l3", 32'(sum3), 32'(es));
        else if (hr[n]) chk("sum_l3_rst", 32'(sum3), 32'd0);
    endtask

    task automatic cycle(input int ta, input int tb, input logic tv, input logic tr);
        a        = W'(ta);
        b        = W'(tb);
        in_valid = tv;
        rst_n    = tr;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int hits;
        int pos;
        int sum_at;

        // Reset with operands 4+4 held.
        cycle(4, 4, 1'b1, 1'b0);
        cycle(4, 4, 1'b1, 1'b0);
        chk("rst_sum", 32'(sum1), 32'd0);
        chk("rst_vld", 32'(vld1), 32'd0);
        chk("rst_sum3", 32'(sum3), 32'd0);
        cycle(4, 4, 1'b1, 1'b1);
        chk("rel_sum", 32'(sum1), 32'd8);
        chk("rel_vld", 32'(vld1), 32'd1);

        // Operand changes, one edge each.
        cycle(4, 4, 1'b1, 1'b1);
        cycle(4, 4, 1'b1, 1'b1);
        for (int k = 3; k <= 6; k++) begin
            cycle(k, 4, 1'b1, 1'b1);
            chk("step_sum", 32'(sum1), 32'(k + 4));
        end

        // Carry boundary.
        cycle(15, 15, 1'b1, 1'b1);
        chk("carry_max", 32'(sum1), 32'd30);
        cycle(15, 1, 1'b1, 1'b1);
        chk("carry_16", 32'(sum1), 32'd16);
        cycle(0, 0, 1'b1, 1'b1);
        chk("zero", 32'(sum1), 32'd0);

        // Glitch between edges must not be captured.
        cycle(7, 2, 1'b1, 1'b1);
        a = 4'd12;
        #2;
        a = 4'd7;
        @(negedge clk);
        check_model();
        chk("glitch", 32'(sum1), 32'd9);

        // Random traffic with occasional resets.
        for (int k = 0; k < 200; k++) begin
            cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) != 0));
        end

        // Reset pulse mid-stream.
        cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 1'b1);
        cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 1'b0);
        chk("mid_rst_sum", 32'(sum1), 32'd0);
        chk("mid_rst_vld", 32'(vld1), 32'd0);
        chk("mid_rst_vld3", 32'(vld3), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 1'b1);
        end

        // Single valid pulse through the 3-stage pipe.
        for (int k = 0; k < 4; k++) cycle(1, 2, 1'b0, 1'b1);
        hits   = 0;
        pos    = -1;
        sum_at = -1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) cycle(9, 7, 1'b1, 1'b1);
            else        cycle(3, 3, 1'b0, 1'b1);
            if (vld3) begin
                hits++;
                pos    = k;
                sum_at = int'(sum3);
            end
        end
        chk("lat3_hits", 32'(hits), 32'd1);
        chk("lat3_pos", 32'(pos), 32'd2);
        chk("lat3_sum", 32'(sum_at), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/add_reg.md
Name: add_reg

Overview:
- Registered unsigned adder. Sums two WIDTH-bit operands and presents a WIDTH+1-bit result, including carry, from a clocked output register.
- Optional extra pipeline stages with a valid qualifier that travels alongside the data.
- Leaf arithmetic block used behind a bundled interface (a, b, sum, clk) in datapath and training benches.

Parameters:
- WIDTH, 4, operand width in bits; sum is WIDTH+1 bits.
- LATENCY, 1, number of register stages from operands to sum; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- in_valid  input  1  operands qualifier; tie to 1 for free-running use.
- sum  output  WIDTH+1  registered a+b, MSB is carry-out.
- out_valid  output  1  sum qualifier, aligned with sum.

Interface:
- One clock; reset is synchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- All state updates on the rising edge of clk only. No asynchronous paths.
- Reset: on an edge with rst_n=0, every pipeline stage clears. sum=0 and out_valid=0 from that edge on.
- Reset mid-operation: in-flight results are discarded. No output becomes valid until LATENCY edges after the first edge with rst_n=1 and in_valid=1.
- Arithmetic:
  - sum = zero-extend(a) + zero-extend(b), computed at WIDTH+1 bits.
  - No overflow is possible and no wrap occurs. Max is (2^WIDTH-1)*2, i.e. 30 for WIDTH=4.
- Stage 1 captures the sum of a and b as sampled at that edge, together with in_valid.
- Stages 2..LATENCY shift unconditionally each edge. There is no stall or backpressure.
- Latency: operands sampled at edge N appear on sum/out_valid after edge N+LATENCY-1 and hold for one cycle. With LATENCY=1, sum follows the operands sampled at the previous edge.
- Data when in_valid=0: the stage still loads a+b, but its valid bit is 0. Consumers must ignore sum while out_valid=0.
- Operand changes between edges have no effect on sum until the next rising edge. Inputs driven nonblocking at the same edge as clk are sampled at the following edge.
- sum is never X after the first reset edge.
- LATENCY outside 1..4 triggers an elaboration-time $error.

Decomposition:
- Package add_pkg holds:
  - DEFAULT_WIDTH = 4;
  - MAX_LATENCY = 4;
  - a helper function sum_width(w) returning w+1.
- Sub-module add_pipe_stage:
  - one register stage holding a WIDTH+1 data field and a valid bit;
  - synchronous active-low clear;
  - instantiated LATENCY times via generate, with stage 1 fed by the combinational adder.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with a=4, b=4 -> sum=0, out_valid=0. Release; after the next edge -> sum=8, out_valid=1.
- Operand change on clock: a=4, b=4; after 3 edges set a=3 -> sum=7 from the following edge. Then a=4 -> 8, a=5 -> 9, a=6 -> 10, each appearing one edge after the change.
- Carry boundary: a=15, b=15 -> sum=30 (5'b11110). a=15, b=1 -> 16. a=0, b=0 -> 0.
- Mid-edge glitch: change a at a negedge and change it back before the next posedge -> sum unaffected.
- Reset mid-stream: drive random operands, then pulse rst_n=0 for 1 edge -> sum=0, out_valid=0 that cycle. Valid results resume LATENCY edges after release.
- LATENCY=3: in_valid pulsed for 1 cycle with a=9, b=7 -> out_valid high exactly 3 edges later with sum=16, low otherwise.
